// File: rtl/kgp_mem_pkg.sv
// Shared types and default widths for the data-memory debug arbiter.
package kgp_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among debug requesters, searching upward from last_grant+1.
module rr_arbiter #(
  parameter int N_DBG = 2,
  parameter int IDX_W = (N_DBG > 1) ? $clog2(N_DBG) : 1
) (
  input  logic [N_DBG-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    cand   = '0;
    winner = last_grant;
    valid  = 1'b0;
    // Walk from farthest to nearest so the closest requester after last_grant wins.
    for (int i = N_DBG; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % N_DBG);
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_dbg_arbiter.sv
// Shares one data-memory port between the CPU (absolute priority) and N_DBG
// read-only debug channels served round-robin, one read every three cycles.
module dmem_dbg_arbiter
  import kgp_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_DBG  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [DATA_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic [DATA_W-1:0]       cpu_rdata,
  input  logic [N_DBG-1:0]        dbg_req,
  input  logic [N_DBG*ADDR_W-1:0] dbg_addr,
  output logic [N_DBG-1:0]        dbg_ack,
  output logic [DATA_W-1:0]       dbg_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int IDX_W = (N_DBG > 1) ? $clog2(N_DBG) : 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant_p1;
  logic [IDX_W-1:0]  rr_win;
  logic              rr_vld;
  logic              cpu_act;
  logic              dbg_issue;
  logic [ADDR_W-1:0] dbg_win_addr;
  logic [ADDR_W-1:0] addr_hold_p1;
  logic [DATA_W-1:0] wdata_hold_p1;

  rr_arbiter #(
    .N_DBG (N_DBG),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (dbg_req),
    .last_grant (last_grant),
    .winner     (rr_win),
    .valid      (rr_vld)
  );

  assign cpu_rdata = mem_rdata;

  // Issue stage: CPU wins the port outright; debug only issues from IDLE.
  always_comb begin
    cpu_act      = cpu_rd | cpu_wr;
    dbg_win_addr = dbg_addr[int'(rr_win)*ADDR_W +: ADDR_W];
    dbg_issue    = !rst && !cpu_act && (state == IDLE) && rr_vld;
    mem_en       = cpu_act | dbg_issue;
    mem_we       = cpu_wr;
    mem_addr     = addr_hold_p1;
    mem_wdata    = wdata_hold_p1;
    if (cpu_act) begin
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end else if (dbg_issue) begin
      mem_addr  = dbg_win_addr;
    end
  end

  // Idle bus keeps the last driven address/data.
  always_ff @(posedge clk) begin
    if (mem_en) begin
      addr_hold_p1  <= mem_addr;
      wdata_hold_p1 <= mem_wdata;
    end
  end

  // Control: IDLE issues, WAIT captures memory data, ACK presents the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N_DBG - 1);
      grant_p1   <= '0;
      dbg_ack    <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dbg_ack <= '0;
          if (dbg_issue) begin
            grant_p1   <= rr_win;
            last_grant <= rr_win;
            state      <= WAIT;
          end
        end
        WAIT: begin
          dbg_rdata          <= mem_rdata;
          dbg_ack            <= '0;
          dbg_ack[grant_p1]  <= 1'b1;
          state              <= ACK;
        end
        ACK: begin
          dbg_ack <= '0;
          state   <= IDLE;
        end
        default: begin
          dbg_ack <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dbg_arbiter.sv
// Directed bench: two arbiter instances (2 and 4 debug channels) on behavioural memories.
module tb_dmem_dbg_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  dbg_req, dbg_ack;
  logic [19:0] dbg_addr;
  logic [31:0] dbg_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] cpu_rdata4;
  logic [3:0]  dbg_req4, dbg_ack4;
  logic [39:0] dbg_addr4;
  logic [31:0] dbg_rdata4;
  logic        mem_en4, mem_we4;
  logic [9:0]  mem_addr4;
  logic [31:0] mem_wdata4, mem_rdata4;

  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem2 [0:1023];
  logic [31:0] mem4 [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_dbg_arbiter #(.DATA_W(32), .ADDR_W(10), .N_DBG(2)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_dbg_arbiter #(.DATA_W(32), .ADDR_W(10), .N_DBG(4)) dut4 (
    .clk(clk), .rst(rst), .cpu_rd(1'b0), .cpu_wr(1'b0), .cpu_addr(32'd0),
    .cpu_wdata(32'd0), .cpu_rdata(cpu_rdata4), .dbg_req(dbg_req4), .dbg_addr(dbg_addr4),
    .dbg_ack(dbg_ack4), .dbg_rdata(dbg_rdata4), .mem_en(mem_en4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4)
  );

  // Synchronous memories: read data one cycle after an enabled read.
  always @(posedge clk) begin
    if (bd_we) begin
      mem2[bd_addr] <= bd_data;
      mem4[bd_addr] <= bd_data;
    end else begin
      if (mem_en) begin
        if (mem_we) mem2[mem_addr] <= mem_wdata;
        else        mem_rdata      <= mem2[mem_addr];
      end
      if (mem_en4) begin
        if (mem_we4) mem4[mem_addr4] <= mem_wdata4;
        else         mem_rdata4      <= mem4[mem_addr4];
      end
    end
  end

  function automatic logic [31:0] pat(input logic [9:0] a);
    return 32'hA5A50000 + {22'd0, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = '0; dbg_addr = '0; dbg_req4 = '0; dbg_addr4 = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0; mem_rdata = '0; mem_rdata4 = '0;
    tick;
    for (int a = 0; a < 1024; a++) begin
      bd_we = 1'b1; bd_addr = 10'(a); bd_data = pat(10'(a));
      tick;
    end
    bd_addr = 10'h010; bd_data = 32'hDEADBEEF; tick;
    bd_addr = 10'h055; bd_data = 32'hCAFEF00D; tick;
    bd_we = 1'b0;
    tick;
    rst = 1'b0; #1;
    check("rst_ack", 32'(dbg_ack), 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_ack4", 32'(dbg_ack4), 32'd0);
    tick;

    // Single debug read on channel 0.
    dbg_req = 2'b01; dbg_addr[9:0] = 10'h010; #1;
    check("rd_en", 32'(mem_en), 32'd1);
    check("rd_we", 32'(mem_we), 32'd0);
    check("rd_addr", 32'(mem_addr), 32'h010);
    tick;
    check("rd_ack_wait", 32'(dbg_ack), 32'd0);
    tick;
    check("rd_ack", 32'(dbg_ack), 32'b01);
    check("rd_data", dbg_rdata, 32'hDEADBEEF);
    tick;
    dbg_req = 2'b00; #1;
    check("idle_en", 32'(mem_en), 32'd0);
    check("idle_we", 32'(mem_we), 32'd0);
    check("idle_hold_addr", 32'(mem_addr), 32'h010);
    tick;
    check("idle_ack", 32'(dbg_ack), 32'd0);

    // CPU reads for four cycles block a channel-1 request.
    cpu_rd = 1'b1; cpu_addr = 32'h0C0; dbg_req = 2'b10; dbg_addr[19:10] = 10'h055; #1;
    check("blk_en", 32'(mem_en), 32'd1);
    check("blk_addr", 32'(mem_addr), 32'h030);
    for (int k = 1; k < 4; k++) begin
      tick;
      cpu_addr = 32'((32'h30 + k) * 4); #1;
      check("blk_cpu_rdata", cpu_rdata, pat(10'(32'h30 + k - 1)));
      check("blk_cpu_addr", 32'(mem_addr), 32'(32'h30 + k));
      check("blk_ack", 32'(dbg_ack), 32'd0);
    end
    tick;
    cpu_rd = 1'b0; #1;
    check("blk_cpu_rdata_last", cpu_rdata, pat(10'h033));
    check("blk_issue_en", 32'(mem_en), 32'd1);
    check("blk_issue_we", 32'(mem_we), 32'd0);
    check("blk_issue_addr", 32'(mem_addr), 32'h055);
    tick;
    check("blk_ack_wait", 32'(dbg_ack), 32'd0);
    tick;
    check("blk_ack", 32'(dbg_ack), 32'b10);
    check("blk_data", dbg_rdata, 32'hCAFEF00D);
    tick;
    dbg_req = 2'b00; #1;
    tick;

    // CPU write to the same word while a debug read is in flight.
    dbg_req = 2'b01; dbg_addr[9:0] = 10'h020; #1;
    check("wr_issue_addr", 32'(mem_addr), 32'h020);
    tick;
    cpu_wr = 1'b1; cpu_addr = 32'h80; cpu_wdata = 32'h12345678; #1;
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'h020);
    check("wr_wdata", mem_wdata, 32'h12345678);
    tick;
    cpu_wr = 1'b0; #1;
    check("wr_old_ack", 32'(dbg_ack), 32'b01);
    check("wr_old_data", dbg_rdata, pat(10'h020));
    tick;
    check("wr_reissue_en", 32'(mem_en), 32'd1);
    check("wr_reissue_addr", 32'(mem_addr), 32'h020);
    tick;
    tick;
    check("wr_new_ack", 32'(dbg_ack), 32'b01);
    check("wr_new_data", dbg_rdata, 32'h12345678);
    tick;
    dbg_req = 2'b00; #1;
    tick;

    // Reset while in WAIT abandons the read; then fairness from a fresh reset.
    dbg_req = 2'b10; dbg_addr[19:10] = 10'h055; #1;
    check("rw_issue_addr", 32'(mem_addr), 32'h055);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; dbg_req = 2'b11; dbg_addr[9:0] = 10'h010; #1;
    check("rw_ack", 32'(dbg_ack), 32'd0);
    check("rw_rdata", dbg_rdata, 32'd0);
    check("rw_first_en", 32'(mem_en), 32'd1);
    check("rw_first_addr", 32'(mem_addr), 32'h010);
    for (int j = 0; j < 4; j++) begin
      tick;
      check("fair_wait", 32'(dbg_ack), 32'd0);
      tick;
      check("fair_ack", 32'(dbg_ack), (j % 2 == 0) ? 32'b01 : 32'b10);
      check("fair_data", dbg_rdata, (j % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
      tick;
      check("fair_gap", 32'(dbg_ack), 32'd0);
    end
    dbg_req = 2'b00; #1;
    tick;

    // Four channels held together: acks at cycles 2, 5, 8, 11.
    dbg_req4 = 4'b1111;
    dbg_addr4 = {10'h103, 10'h102, 10'h101, 10'h100};
    #1;
    check("starv_ack_0", 32'(dbg_ack4), 32'd0);
    for (int cyc = 1; cyc < 14; cyc++) begin
      tick;
      if (cyc == 2 || cyc == 5 || cyc == 8 || cyc == 11) begin
        check("starv_ack", 32'(dbg_ack4), 32'd1 << ((cyc - 2) / 3));
        check("starv_data", dbg_rdata4, pat(10'(32'h100 + (cyc - 2) / 3)));
      end else begin
        check("starv_gap", 32'(dbg_ack4), 32'd0);
      end
    end
    dbg_req4 = 4'b0000;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
